// File: rtl/sc_div_pkg.sv
// Shared types and parameter validation for the in-stream correlation-based
// stochastic divider array.
package sc_div_pkg;

  typedef enum logic [2:0] {
    SYNC_PASS    = 3'd0,
    SYNC_STORE   = 3'd1,
    SYNC_RELEASE = 3'd2,
    SYNC_IDLE    = 3'd3,
    SYNC_OVF     = 3'd4
  } sync_ev_t;

  // True when the trace depth is a power of two no smaller than 2 and the
  // synchronizer can hold at least one pending dividend bit.
  function automatic bit check_params(input int trace, input int sync_depth);
    bit ok;
    ok = (trace >= 2) && ((trace & (trace - 1)) == 0) && (sync_depth >= 1);
    return ok;
  endfunction

endpackage

// File: rtl/skew_sync_cnt.sv
// Single-channel skewed synchronizer: delays dividend ones that arrive without
// a divisor one so that every emitted dividend one coincides with a divisor one.
module skew_sync_cnt
  import sc_div_pkg::*;
#(
  parameter int SYNC_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic a,
  input  logic b,
  output logic a_sync,
  output logic ovf
);

  localparam int CW = $clog2(SYNC_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_DEPTH);

  logic [CW-1:0] cnt;
  sync_ev_t      ev;

  always_comb begin
    ev = SYNC_IDLE;
    case ({a, b})
      2'b11:   ev = SYNC_PASS;
      2'b10:   ev = (cnt == CNT_MAX) ? SYNC_OVF : SYNC_STORE;
      2'b01:   ev = (cnt != {CW{1'b0}}) ? SYNC_RELEASE : SYNC_IDLE;
      default: ev = SYNC_IDLE;
    endcase
  end

  always_comb begin
    a_sync = 1'b0;
    ovf    = 1'b0;
    if (en) begin
      a_sync = (ev == SYNC_PASS) || (ev == SYNC_RELEASE) || (ev == SYNC_OVF);
      ovf    = (ev == SYNC_OVF);
    end else begin
      a_sync = 1'b0;
      ovf    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (en) begin
      case (ev)
        SYNC_STORE:   cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
        SYNC_RELEASE: cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
        default:      cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/iscbdiv_array.sv
// Multi-channel ISCB stochastic divider: per channel a skewed synchronizer feeds
// a trace register that replays past quotient bits whenever the divisor is 0.
module iscbdiv_array
  import sc_div_pkg::*;
#(
  parameter int CH         = 1,
  parameter int SYNC_DEPTH = 4,
  parameter int TRACE      = 2,
  parameter int RNG_W      = $clog2(TRACE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [CH*RNG_W-1:0] rand_idx,
  input  logic [CH-1:0]       dividend,
  input  logic [CH-1:0]       divisor,
  output logic [CH-1:0]       quotient,
  output logic [CH-1:0]       trace_full,
  output logic [CH-1:0]       sync_ovf
);

  localparam int FW = $clog2(TRACE + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(TRACE);

  if (!check_params(TRACE, SYNC_DEPTH)) begin : g_bad_params
    $error("iscbdiv_array: TRACE must be a power of 2 >= 2 and SYNC_DEPTH >= 1");
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic             a_sync;
    logic             ovf;
    logic             q;
    logic [RNG_W-1:0] idx;
    logic [TRACE-1:0] trace;
    logic [FW-1:0]    fcnt;
    logic [FW-1:0]    fcnt_next;
    logic             full;

    skew_sync_cnt #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .clr    (clr),
      .a      (dividend[c]),
      .b      (divisor[c]),
      .a_sync (a_sync),
      .ovf    (ovf)
    );

    assign idx = rand_idx[c*RNG_W +: RNG_W];

    // Outputs are held low while reset is asserted, without waiting for an edge.
    always_comb begin
      q = 1'b0;
      if (en && !rst) begin
        q = divisor[c] ? a_sync : trace[idx];
      end else begin
        q = 1'b0;
      end
    end

    always_comb begin
      fcnt_next = fcnt;
      if (clr) begin
        fcnt_next = {FW{1'b0}};
      end else if (en && divisor[c] && (fcnt != FILL_MAX)) begin
        fcnt_next = fcnt + {{(FW-1){1'b0}}, 1'b1};
      end else begin
        fcnt_next = fcnt;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        trace <= {TRACE{1'b0}};
        fcnt  <= {FW{1'b0}};
        full  <= 1'b0;
      end else begin
        fcnt <= fcnt_next;
        full <= (fcnt_next == FILL_MAX);
        if (clr) begin
          trace <= {TRACE{1'b0}};
        end else if (en && divisor[c]) begin
          trace <= {q, trace[TRACE-1:1]};
        end
      end
    end

    assign quotient[c]   = q;
    assign trace_full[c] = full;
    assign sync_ovf[c]   = ovf && !rst;
  end

endmodule

// File: tb/tb_iscbdiv_array.sv
// Directed self-checking bench for iscbdiv_array with CH=4, SYNC_DEPTH=4, TRACE=4.
module tb_iscbdiv_array;

  localparam int CH = 4;
  localparam int SYNC_DEPTH = 4;
  localparam int TRACE = 4;
  localparam int RNG_W = 2;

  logic                clk;
  logic                rst;
  logic                en;
  logic                clr;
  logic [CH*RNG_W-1:0] rand_idx;
  logic [CH-1:0]       dividend;
  logic [CH-1:0]       divisor;
  logic [CH-1:0]       quotient;
  logic [CH-1:0]       trace_full;
  logic [CH-1:0]       sync_ovf;

  int checks;
  int errors;

  iscbdiv_array #(
    .CH(CH), .SYNC_DEPTH(SYNC_DEPTH), .TRACE(TRACE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .rand_idx(rand_idx),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .trace_full(trace_full), .sync_ovf(sync_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_idx(input logic [1:0] i);
    rand_idx = {4{i}};
  endtask

  task automatic flush();
    clr = 1'b1; dividend = '0; divisor = '0;
    next();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; dividend = '0; divisor = '0; rand_idx = '0;
    next(); next();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (quotient !== 4'b0000 || trace_full !== 4'b0000 || sync_ovf !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state q=%b full=%b ovf=%b want 0000/0000/0000", quotient, trace_full, sync_ovf);
    end
    next();
    dividend = 4'b0011; divisor = 4'b0011;
    for (int i = 0; i < 4; i++) next();
    @(negedge clk);
    checks++;
    if (quotient !== 4'b0011 || trace_full !== 4'b0011) begin
      errors++;
      $display("FAIL pre_reset_stream q=%b full=%b want 0011/0011", quotient, trace_full);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (quotient !== 4'b0000 || trace_full !== 4'b0000 || sync_ovf !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset q=%b full=%b ovf=%b want 0000/0000/0000", quotient, trace_full, sync_ovf);
    end
    next();
    rst = 1'b0; dividend = '0; divisor = '0;
    for (int i = 0; i < 4; i++) begin
      set_all_idx(2'(i));
      @(negedge clk);
      checks++;
      if (quotient !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_read idx=%0d q=%b want 0000", i, quotient);
      end
      next();
    end
  endtask

  task automatic test_sync();
    logic [4:0] exp_q;
    flush();
    set_all_idx(2'd0);
    dividend = 4'b0001; divisor = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (sync_ovf !== ((i == 5) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL sync_ovf cycle=%0d ovf=%b want %b", i, sync_ovf, (i == 5) ? 4'b0001 : 4'b0000);
      end
      next();
    end
    exp_q = 5'b11110;
    dividend = 4'b0000; divisor = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (quotient[0] !== exp_q[4-i] || sync_ovf !== 4'b0000) begin
        errors++;
        $display("FAIL sync_release cycle=%0d q=%b ovf=%b want %b/0000", i + 1, quotient[0], sync_ovf, exp_q[4-i]);
      end
      next();
    end
  endtask

  task automatic test_trace_fill();
    logic [3:0] a_seq;
    logic [3:0] rd_exp;
    flush();
    a_seq = 4'b1101;
    divisor = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      dividend = {3'b000, a_seq[3-i]};
      @(negedge clk);
      checks++;
      if (quotient[0] !== a_seq[3-i] || trace_full[0] !== 1'b0) begin
        errors++;
        $display("FAIL fill cycle=%0d q=%b full=%b want %b/0", i, quotient[0], trace_full[0], a_seq[3-i]);
      end
      next();
    end
    dividend = '0; divisor = '0;
    rd_exp = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      set_all_idx(2'(i));
      @(negedge clk);
      checks++;
      if (quotient[0] !== rd_exp[i] || trace_full[0] !== 1'b1) begin
        errors++;
        $display("FAIL readout idx=%0d q=%b full=%b want %b/1", i, quotient[0], trace_full[0], rd_exp[i]);
      end
      next();
    end
  endtask

  task automatic test_enable_clear();
    logic [3:0] rd_exp;
    rd_exp = 4'b1011;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dividend = 4'(i); divisor = 4'(i + 3);
      set_all_idx(2'(i));
      @(negedge clk);
      checks++;
      if (quotient !== 4'b0000 || sync_ovf !== 4'b0000) begin
        errors++;
        $display("FAIL en_low cycle=%0d q=%b ovf=%b want 0000/0000", i, quotient, sync_ovf);
      end
      next();
    end
    en = 1'b1; dividend = '0; divisor = '0;
    for (int i = 0; i < 4; i++) begin
      set_all_idx(2'(i));
      @(negedge clk);
      checks++;
      if (quotient[0] !== rd_exp[i] || trace_full[0] !== 1'b1) begin
        errors++;
        $display("FAIL reenable_hold idx=%0d q=%b full=%b want %b/1", i, quotient[0], trace_full[0], rd_exp[i]);
      end
      next();
    end
    dividend = 4'b0001; divisor = 4'b0000;
    next(); next();
    en = 1'b0; clr = 1'b1;
    next();
    en = 1'b1; clr = 1'b0; dividend = '0; divisor = '0;
    for (int i = 0; i < 4; i++) begin
      set_all_idx(2'(i));
      @(negedge clk);
      checks++;
      if (quotient[0] !== 1'b0 || trace_full[0] !== 1'b0) begin
        errors++;
        $display("FAIL clr_trace idx=%0d q=%b full=%b want 0/0", i, quotient[0], trace_full[0]);
      end
      next();
    end
    divisor = 4'b0001;
    @(negedge clk);
    checks++;
    if (quotient[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_cnt q=%b want 0", quotient[0]);
    end
    next();
  endtask

  task automatic test_independence();
    logic ab;
    flush();
    set_all_idx(2'd0);
    for (int i = 1; i <= 5; i++) begin
      ab = (i % 2) == 1;
      dividend = {ab, 1'b1, ab, ab};
      divisor  = {ab, 1'b0, ab, ab};
      @(negedge clk);
      checks++;
      if (sync_ovf !== ((i == 5) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL indep_ovf cycle=%0d ovf=%b want %b", i, sync_ovf, (i == 5) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if ({quotient[3], quotient[1:0]} !== {ab, ab, ab}) begin
        errors++;
        $display("FAIL indep_q cycle=%0d q=%b want ch3,1,0=%b", i, quotient, {ab, ab, ab});
      end
      next();
    end
  endtask

  task automatic test_statistics();
    int ones0;
    int ones1;
    ones0 = 0; ones1 = 0;
    flush();
    for (int i = 0; i < 4096; i++) begin
      divisor[0]  = ($urandom_range(0, 1) == 1);
      dividend[0] = ($urandom_range(0, 3) == 0);
      divisor[1]  = ($urandom_range(0, 3) != 0);
      dividend[1] = ($urandom_range(0, 7) < 3);
      dividend[3:2] = 2'b00; divisor[3:2] = 2'b00;
      rand_idx = 8'($urandom_range(0, 255));
      #3;
      ones0 += int'(quotient[0]);
      ones1 += int'(quotient[1]);
      next();
    end
    checks++;
    if (ones0 < 2048 - 123 || ones0 > 2048 + 123) begin
      errors++;
      $display("FAIL stat_ch0 ones=%0d want 2048+-123", ones0);
    end
    checks++;
    if (ones1 < 2048 - 123 || ones1 > 2048 + 123) begin
      errors++;
      $display("FAIL stat_ch1 ones=%0d want 2048+-123", ones1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sync();
    test_trace_fill();
    test_enable_clear();
    test_independence();
    test_statistics();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
